video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Video timing master for the HDMI/RGB output path. Runs horizontal and vertical counters
//  from the pixel clock and generates HS/VS/DE. Requests pixels from the pattern/display
//  source by issuing pixel_xpos/pixel_ypos one cycle ahead, which absorbs that source's
//  one-cycle registered latency. Merges the returned pixel_data onto video_rgb, aligned to DE.
//  Sits between the pixel source and the RGB-to-TMDS encoder.
// PARAMETERS
//  H_SYNC   11'd40    hsync width, pixel clocks
//  H_BACK   11'd220   h back porch
//  H_DISP   11'd1280  active pixels per line
//  H_FRONT  11'd110   h front porch
//  V_SYNC   11'd5     vsync width, lines
//  V_BACK   11'd20    v back porch
//  V_DISP   11'd720   active lines
//  V_FRONT  11'd5     v front porch
//  SYNC_POL 1'b1      active level of video_hs/video_vs (1 = active-high)
//  H_TOTAL and V_TOTAL are derived: sum of the four terms (1650 and 750 by default).
// PORTS
//  pixel_clk    in   1   pixel clock (74.25 MHz for 720p60)
//  sys_rst_n    in   1   asynchronous active-low reset
//  pixel_data   in   24  RGB888 from source; valid one cycle after data_req
//  pixel_xpos   out  11  requested pixel column, 0..H_DISP-1; 0 when data_req=0
//  pixel_ypos   out  11  requested pixel row, 0..V_DISP-1; 0 when data_req=0
//  data_req     out  1   pixel request strobe, one cycle ahead of video_de
//  video_hs     out  1   horizontal sync
//  video_vs     out  1   vertical sync
//  video_de     out  1   data enable
//  video_rgb    out  24  pixel_data while video_de=1, else 24'd0
//  frame_start  out  1   one-cycle pulse at the start of each frame
// BEHAVIOUR
//  - cnt_h (12b) counts 0..H_TOTAL-1 every clock and wraps to 0.
//  - cnt_v (12b) increments only when cnt_h==H_TOTAL-1, and wraps to 0 after V_TOTAL-1.
//  - Both counters reset to 0 asynchronously.
//  - Line layout in cnt_h order: sync [0,H_SYNC), back porch, active, front porch.
//    The frame uses the same layout in cnt_v order.
//  - HA = H_SYNC+H_BACK (first active column, 260). VA = V_SYNC+V_BACK (first active row, 25).
//  - video_hs = SYNC_POL when cnt_h<H_SYNC, else ~SYNC_POL.
//  - video_vs = SYNC_POL when cnt_v<V_SYNC, else ~SYNC_POL. Both are combinational from the counters.
//  - video_de = 1 iff HA<=cnt_h<HA+H_DISP and VA<=cnt_v<VA+V_DISP.
//  - data_req = 1 iff HA-1<=cnt_h<HA+H_DISP-1 and cnt_v is in the active rows.
//    data_req therefore leads video_de by exactly 1 cycle and has the same width, H_DISP.
//  - When data_req=1: pixel_xpos = cnt_h-(HA-1) and pixel_ypos = cnt_v-VA. Otherwise both are 0.
//  - The source registers its output, so the pixel_data sampled while video_de=1 belongs to
//    the previous cycle's request. video_rgb = video_de ? pixel_data : 24'd0 (combinational).
//  - frame_start: registered output, reset 0.
//    Set for one cycle on the clock after the counters reach (cnt_h=0, cnt_v=0) from a wrap.
//    It is not set after reset release; the first pulse comes at the end of frame 1.
//  - Output values during reset (counters at 0, sync region):
//    video_hs=video_vs=SYNC_POL; video_de=0; data_req=0; pixel_xpos=pixel_ypos=0;
//    video_rgb=0; frame_start=0.
//  - Reset asserted mid-line or mid-frame: counters return to 0 immediately.
//    No partial DE burst continues. After release, the counters restart at (0,0) on the
//    first clock edge.
//  - pixel_data outside the DE window is ignored.
//  - Parameter rule: every term >=1 and H_TOTAL,V_TOTAL <= 4095. No runtime reconfiguration.
// TESTING
//  1. Reset, then release.
//     -> All outputs hold their reset values.
//     -> cnt_h=0 on the first edge after release; video_hs stays active for exactly 40 clocks.
//  2. Default parameters, one line period.
//     -> HS period = 1650 clocks.
//     -> On row 25: data_req first high at cnt_h=259 with pixel_xpos=0, and high for 1280 clocks.
//     -> video_de first high at cnt_h=260, for 1280 clocks.
//  3. Source model registers pixel_data={8'h00,pixel_ypos[7:0],pixel_xpos[7:0]}.
//     -> video_rgb at DE cycle k of row r = {8'h00,r[7:0],k[7:0]}.
//     -> video_rgb = 0 outside DE.
//  4. Frame-level timing.
//     -> VS active for exactly 5*1650 = 8250 clocks.
//     -> 720 DE bursts per frame.
//     -> frame_start period = 1237500 clocks, each pulse 1 cycle wide.
//  5. Assert reset at cnt_h=700 on row 300.
//     -> video_de drops the same cycle.
//     -> After release, the first data_req comes 259 clocks after cnt_h=0 on row 25.
//  6. Small timing (1/1/4/1, 1/1/3/1) with SYNC_POL=0.
//     -> H_TOTAL=7, V_TOTAL=6.
//     -> HS is low for 1 clock per line.
//     -> DE is a 4-clock burst on rows 2..4.
//     -> The counter wraps cleanly across 3 frames.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Video timing master for the HDMI/RGB output path. Free-running horizontal and
// vertical counters drive HS/VS/DE. Pixel coordinates are requested one clock
// ahead of DE so that a source with one registered stage returns each pixel in
// the same cycle that DE marks it active. The returned pixel is merged onto
// video_rgb inside the DE window and forced to zero outside it.

`timescale 1ns / 1ps

module video_timing_gen #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  // Line and frame geometry, all widened to the 12-bit counter width.
  localparam logic [11:0] H_TOTAL     = 12'(H_SYNC) + 12'(H_BACK) + 12'(H_DISP) + 12'(H_FRONT);
  localparam logic [11:0] V_TOTAL     = 12'(V_SYNC) + 12'(V_BACK) + 12'(V_DISP) + 12'(V_FRONT);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC) + 12'(H_BACK);
  localparam logic [11:0] H_ACT_END   = H_ACT_START + 12'(H_DISP);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC) + 12'(V_BACK);
  localparam logic [11:0] V_ACT_END   = V_ACT_START + 12'(V_DISP);
  // The request window is the active window shifted one column earlier.
  localparam logic [11:0] H_REQ_START = H_ACT_START - 12'd1;
  localparam logic [11:0] H_REQ_END   = H_ACT_END - 12'd1;

  logic [11:0] cnt_h;
  logic [11:0] cnt_v;
  logic        h_last;
  logic        v_last;
  logic        h_active;
  logic        h_request;
  logic        v_active;
  logic        frame_wrap_q;

  // Decode counter positions into line/frame regions.
  always_comb begin
    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    h_last    = 1'b0;
    v_last    = 1'b0;
    h_active  = 1'b0;
    h_request = 1'b0;
    v_active  = 1'b0;
    h_last    = (cnt_h == H_TOTAL - 12'd1);
    v_last    = (cnt_v == V_TOTAL - 12'd1);
    h_active  = (cnt_h >= H_ACT_START) && (cnt_h < H_ACT_END);
    h_request = (cnt_h >= H_REQ_START) && (cnt_h < H_REQ_END);
    v_active  = (cnt_v >= V_ACT_START) && (cnt_v < V_ACT_END);
  end

  // Horizontal counter wraps every line; vertical counter steps at end of line.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (h_last) begin
      cnt_h <= '0;
      if (v_last) begin
        cnt_v <= '0;
      end else begin
        cnt_v <= cnt_v + 12'd1;
      end
    end else begin
      cnt_h <= cnt_h + 12'd1;
    end
  end

  // Frame pulse: frame_wrap_q marks the (0,0) cycle reached by a wrap, and
  // frame_start follows it one clock later. Leaving reset at (0,0) does not
  // set frame_wrap_q, so the first pulse only appears after frame 1 ends.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_wrap_q <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_wrap_q <= h_last & v_last;
      frame_start  <= frame_wrap_q;
    end
  end

  // Sync, enable and request outputs follow the counters combinationally.
  always_comb begin
    video_hs   = (cnt_h < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    video_vs   = (cnt_v < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    video_de   = h_active & v_active;
    data_req   = h_request & v_active;
    pixel_xpos = data_req ? 11'(cnt_h - H_REQ_START) : 11'd0;
    pixel_ypos = data_req ? 11'(cnt_v - V_ACT_START) : 11'd0;
    // The source's registered pixel answers last cycle's request, which lines
    // up with this cycle's DE.
    video_rgb  = video_de ? pixel_data : 24'd0;
  end

endmodule
